// File: rtl/music_sequencer_pkg.sv
// Shared types and constants for the music sequencer.
// Holds the FSM state encoding, silence tone and default song lengths.
package music_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY_BG  = 2'd1,
        PLAY_JGL = 2'd2,
        PAUSE    = 2'd3
    } seq_state_t;

    localparam logic [31:0] SILENCE     = 32'd20000;
    localparam int          LEN_BG_DEF  = 256;
    localparam int          LEN_JGL_DEF = 64;

endpackage

// File: rtl/music_sequencer_tick.sv
// Beat divider: counts clocks while enabled and flags the last one.
// Holds its count while disabled so a paused beat resumes where it left off.
module beat_tick_gen #(
    parameter int BEAT_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BEAT_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = en && (div_cnt == CNT_MAX);

    // Divider counter: clear on request, wrap at the last clock of a beat.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_cnt == CNT_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Background song / one-shot jingle sequencer with pause.
// Drives the song ROM index and registers the resulting tone.
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int BEAT_DIV = 12_500_000,
    parameter int LEN_BG   = LEN_BG_DEF,
    parameter int LEN_JGL  = LEN_JGL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bg_en,
    input  logic        jingle_req,
    input  logic        pause,
    input  logic [31:0] tone_in,
    output logic [8:0]  beat_num,
    output logic        song_sel,
    output logic [31:0] tone,
    output logic        busy,
    output logic        jingle_done
);

    localparam logic [8:0] BG_LAST  = 9'(LEN_BG - 1);
    localparam logic [8:0] JGL_LAST = 9'(LEN_JGL - 1);

    seq_state_t state, state_n;
    seq_state_t ret_state, ret_n;
    logic [8:0] beat_n;
    logic [8:0] bg_save, save_n;
    logic       done_n;
    logic       playing;
    logic       en;
    logic       clr;
    logic       tick;

    assign playing  = (state == PLAY_BG) || (state == PLAY_JGL);
    assign busy     = (state != IDLE);
    assign song_sel = (state == PLAY_JGL) ||
                      ((state == PAUSE) && (ret_state == PLAY_JGL));

    beat_tick_gen #(
        .BEAT_DIV(BEAT_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr),
        .tick(tick)
    );

    // State, index and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            beat_num    <= '0;
            bg_save     <= '0;
            tone        <= SILENCE;
            jingle_done <= 1'b0;
        end else begin
            state       <= state_n;
            ret_state   <= ret_n;
            beat_num    <= beat_n;
            bg_save     <= save_n;
            tone        <= playing ? tone_in : SILENCE;
            jingle_done <= done_n;
        end
    end

    // Next-state logic: song selection, preemption, pause and beat stepping.
    always_comb begin
        state_n = state;
        ret_n   = ret_state;
        beat_n  = beat_num;
        save_n  = bg_save;
        done_n  = 1'b0;
        clr     = 1'b0;
        en      = playing && !pause;
        unique case (state)
            IDLE: begin
                clr    = 1'b1;
                beat_n = '0;
                if (jingle_req) begin
                    state_n = PLAY_JGL;
                    save_n  = '0;
                end else if (bg_en) begin
                    state_n = PLAY_BG;
                end
            end
            PLAY_BG: begin
                if (!bg_en) begin
                    state_n = IDLE;
                    beat_n  = '0;
                end else if (pause) begin
                    state_n = PAUSE;
                    ret_n   = PLAY_BG;
                end else if (jingle_req) begin
                    save_n  = beat_num;
                    state_n = PLAY_JGL;
                    beat_n  = '0;
                    clr     = 1'b1;
                end else if (tick) begin
                    beat_n = (beat_num == BG_LAST) ? 9'd0 : beat_num + 9'd1;
                end
            end
            PLAY_JGL: begin
                if (pause) begin
                    state_n = PAUSE;
                    ret_n   = PLAY_JGL;
                end else if (tick) begin
                    if (beat_num == JGL_LAST) begin
                        done_n = 1'b1;
                        if (bg_en) begin
                            state_n = PLAY_BG;
                            beat_n  = bg_save;
                        end else begin
                            state_n = IDLE;
                            beat_n  = '0;
                        end
                    end else begin
                        beat_n = beat_num + 9'd1;
                    end
                end
            end
            PAUSE: begin
                if ((ret_state == PLAY_BG) && !bg_en) begin
                    state_n = IDLE;
                    beat_n  = '0;
                end else if (!pause) begin
                    state_n = ret_state;
                end
            end
            default: begin
                state_n = IDLE;
                beat_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a short beat and short songs.
// Expected values are worked out by hand from the edge count.
module tb_music_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bg_en;
    logic        jingle_req;
    logic        pause;
    logic [31:0] tone_in;
    logic [8:0]  beat_num;
    logic        song_sel;
    logic [31:0] tone;
    logic        busy;
    logic        jingle_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    music_sequencer #(
        .BEAT_DIV(4),
        .LEN_BG  (8),
        .LEN_JGL (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bg_en      (bg_en),
        .jingle_req (jingle_req),
        .pause      (pause),
        .tone_in    (tone_in),
        .beat_num   (beat_num),
        .song_sel   (song_sel),
        .tone       (tone),
        .busy       (busy),
        .jingle_done(jingle_done)
    );

    always #5 clk = ~clk;

    // ROM stand-in: background 1000+idx, jingle 5000+idx.
    always_comb begin
        tone_in = song_sel ? 32'd5000 + 32'(beat_num)
                           : 32'd1000 + 32'(beat_num);
    end

    // Count completion pulses.
    always @(posedge clk) begin
        if (jingle_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        bg_en      = 1'b0;
        jingle_req = 1'b0;
        pause      = 1'b0;
        step(3);
        check("rst_beat", 32'(beat_num), 0);
        check("rst_sel", 32'(song_sel), 0);
        check("rst_tone", tone, 20000);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(jingle_done), 0);

        rst   = 1'b0;
        bg_en = 1'b1;
        step(1);
        check("bg_start_beat", 32'(beat_num), 0);
        check("bg_start_busy", 32'(busy), 1);
        check("bg_start_tone", tone, 20000);
        step(1);
        check("bg_tone0", tone, 1000);
        step(3);
        check("bg_beat1", 32'(beat_num), 1);
        check("bg_tone_lag", tone, 1000);
        step(1);
        check("bg_tone1", tone, 1001);
        step(23);
        check("bg_beat7", 32'(beat_num), 7);
        step(4);
        check("bg_wrap", 32'(beat_num), 0);
        step(21);
        check("bg_beat5", 32'(beat_num), 5);

        jingle_req = 1'b1;
        step(1);
        jingle_req = 1'b0;
        check("jgl_sel", 32'(song_sel), 1);
        check("jgl_beat0", 32'(beat_num), 0);
        step(1);
        check("jgl_tone0", tone, 5000);
        step(14);
        check("jgl_beat3", 32'(beat_num), 3);
        check("jgl_no_done", 32'(jingle_done), 0);
        step(1);
        check("jgl_done", 32'(jingle_done), 1);
        check("resume_beat", 32'(beat_num), 5);
        check("resume_sel", 32'(song_sel), 0);
        step(1);
        check("done_once", 32'(jingle_done), 0);

        step(1);
        pause = 1'b1;
        step(2);
        check("pause_tone", tone, 20000);
        check("pause_beat", 32'(beat_num), 5);
        check("pause_busy", 32'(busy), 1);
        step(8);
        pause = 1'b0;
        step(2);
        check("unpause_hold", 32'(beat_num), 5);
        step(1);
        check("unpause_next", 32'(beat_num), 6);

        jingle_req = 1'b1;
        step(1);
        jingle_req = 1'b0;
        bg_en      = 1'b0;
        step(5);
        check("jgl2_beat1", 32'(beat_num), 1);
        jingle_req = 1'b1;
        step(1);
        jingle_req = 1'b0;
        check("jgl_req_ignored", 32'(beat_num), 1);
        check("jgl_req_sel", 32'(song_sel), 1);
        step(10);
        check("jgl2_done", 32'(jingle_done), 1);
        check("jgl2_idle_busy", 32'(busy), 0);
        check("jgl2_idle_beat", 32'(beat_num), 0);
        step(1);
        check("jgl2_idle_tone", tone, 20000);

        bg_en      = 1'b1;
        jingle_req = 1'b1;
        step(1);
        jingle_req = 1'b0;
        check("both_sel", 32'(song_sel), 1);
        check("both_beat", 32'(beat_num), 0);
        step(16);
        check("both_done", 32'(jingle_done), 1);
        check("both_bg_beat", 32'(beat_num), 0);
        check("both_bg_sel", 32'(song_sel), 0);
        check("both_bg_busy", 32'(busy), 1);

        jingle_req = 1'b1;
        step(1);
        jingle_req = 1'b0;
        step(9);
        check("jgl3_beat2", 32'(beat_num), 2);
        rst = 1'b1;
        step(1);
        check("mid_rst_beat", 32'(beat_num), 0);
        check("mid_rst_sel", 32'(song_sel), 0);
        check("mid_rst_tone", tone, 20000);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(jingle_done), 0);
        bg_en = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        check("done_pulses", 32'(done_cnt), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
